instfetch: RTL and testbench
============================

Name: instfetch

Overview:
- Producer end of the fetch-to-queue interface.
- Holds the architectural fetch PC and looks it up in a small direct-mapped instruction cache.
- On a miss, requests the 32-bit word from the memory controller.
- Pushes one {instruction, pc} pair per cycle into the instruction queue whenever the queue can accept it.
- On a reorder-buffer redirect, flushes in-flight work and restarts at the supplied PC.

Parameters:
- ICacheLines, 16, number of one-word cache lines (power of two).
- ICacheIndexWidth, 4, log2(ICacheLines).
- ResetPC, 32'h0, fetch PC after reset.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, asynchronous and active-low; 0 clears all state immediately.
- rdy_in  input  1  global stall; when 0, no state changes.
- instqueue_if_rdy_in  input  1  queue has room for one entry this cycle.
- if_instqueue_en_out  output  1  one-cycle push strobe.
- if_instqueue_inst_out  output  IDWidth(32)  instruction word being pushed.
- if_instqueue_pc_out  output  AddressWidth(32)  PC of the pushed instruction.
- if_mc_en_out  output  1  memory read request, held high until served or aborted.
- if_mc_addr_out  output  AddressWidth  word-aligned request address.
- mc_if_rdy_in  input  1  one-cycle strobe: mc_if_data_in is valid.
- mc_if_data_in  input  32  fetched word, little-endian assembled.
- rob_if_rst_in  input  1  redirect or flush request.
- rob_if_pc_in  input  AddressWidth  redirect target.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - pc=ResetPC, state=LOOKUP, all cache valid bits 0.
  - if_instqueue_en_out=0, if_instqueue_inst_out=0, if_instqueue_pc_out=0.
  - if_mc_en_out=0, if_mc_addr_out=0.
- rdy_in=0: every register holds, including if_mc_en_out. An mc_if_rdy_in strobe arriving while rdy_in=0 is lost; the memory controller is gated by the same rdy_in, so this cannot happen.
- Cache geometry:
  - index = pc[ICacheIndexWidth+1:2]
  - tag = pc[31:ICacheIndexWidth+2]
  - Line = valid bit + tag + 32-bit data.
- Registered outputs: if_instqueue_en_out defaults to 0 every cycle, so the strobe lasts exactly one cycle.
- State LOOKUP:
  - Hit and instqueue_if_rdy_in=1: next cycle en_out=1 with inst=line data and pc_out=pc; pc<=pc+4 (mod 2^32 wrap, no carry-out). Sustained hits give one push per cycle.
  - Hit and instqueue_if_rdy_in=0: hold; no push, no PC change.
  - Miss: if_mc_en_out<=1, if_mc_addr_out<=pc, state<=WAIT. The miss is taken regardless of queue readiness.
- State WAIT:
  - Hold the request until mc_if_rdy_in=1.
  - On the strobe: write the line (valid=1, tag, data), set if_mc_en_out<=0, state<=LOOKUP.
  - The next cycle re-looks up, hits, and pushes. Miss-to-push latency is therefore memory latency + 2 cycles.
- Redirect (rob_if_rst_in=1 with rdy_in=1) has highest priority over everything in the same cycle:
  - pc<=rob_if_pc_in, state<=LOOKUP, if_mc_en_out<=0, en_out<=0.
  - A cache fill arriving in that same cycle is still written, since the data is correct for its address. It is never pushed.
  - The cache is not invalidated.
  - The memory controller drops any request whose enable falls before its rdy strobe.
- rob_if_pc_in low two bits are ignored (forced to 0).
- A push and a queue-side flush in the same cycle: the queue discards the push. This block needs no special handling beyond the redirect.
- Self-modifying code is unsupported; no invalidate port.

Decomposition:
- Shared constant.vh already supplies IDWidth and AddressWidth.
- Add to constant.vh:
  - state encodings LOOKUP=1'b0 and WAIT=1'b1;
  - ICacheLines default.
- One sub-module, icache:
  - Holds the valid/tag/data arrays.
  - Combinational read port: hit, data.
  - Synchronous write port: en, addr, data.
  - Async active-low clear of the valid bits.
- instfetch keeps the FSM, the PC and the queue/memory handshakes.

Test Plan:
1. Reset then cold start: ResetPC=0, queue always ready; the memory controller returns 32'h00000013 after 3 cycles for each address. Expect:
   - if_mc_en_out rises with addr 0;
   - the push carries pc=0, inst=32'h00000013 two cycles after mc_if_rdy_in;
   - then addr 4 is requested.
2. Warm loop: redirect to 0 after addresses 0..12 are cached. Expect four back-to-back pushes, pc 0,4,8,12, with no if_mc_en_out.
3. Backpressure: instqueue_if_rdy_in=0 for 5 cycles during hits. Expect:
   - no en_out and pc stable throughout;
   - a push resumes the cycle after ready returns, with no duplicate or skipped PC.
4. Redirect mid-miss: in WAIT for addr 32'h40, assert rob_if_rst_in with pc 32'h100. Expect:
   - if_mc_en_out falls the next cycle;
   - the 32'h40 data is never pushed;
   - the next request is 32'h100.
5. Conflict eviction: fetch 32'h0 then 32'h40 (same index, 16 lines). Expect a refetch of 32'h0 to miss and request memory again.
6. Async reset mid-WAIT: drop rst_in between clock edges. Expect:
   - if_mc_en_out=0 immediately, without waiting for an edge;
   - after release, all lines are invalid and fetching restarts at ResetPC.

Source files
------------

// File: rtl/instfetch_pkg.sv
// Shared widths, defaults and fetch FSM encoding for the instruction fetch unit.
package instfetch_pkg;

    localparam int unsigned IDWidth            = 32;
    localparam int unsigned AddressWidth       = 32;
    localparam int unsigned ICacheLinesDefault = 16;

    typedef enum logic [0:0] {
        StLookup = 1'b0,
        StWait   = 1'b1
    } if_state_e;

endpackage

// File: rtl/instfetch_icache.sv
// Direct-mapped one-word-per-line instruction cache: combinational read, synchronous fill.
module instfetch_icache
    import instfetch_pkg::*;
#(
    parameter int unsigned Lines      = ICacheLinesDefault,
    parameter int unsigned IndexWidth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [AddressWidth-1:0] rd_addr_i,
    output logic                    rd_hit_o,
    output logic [IDWidth-1:0]      rd_data_o,
    input  logic                    wr_en_i,
    input  logic [AddressWidth-1:0] wr_addr_i,
    input  logic [IDWidth-1:0]      wr_data_i
);

    localparam int unsigned TagWidth = AddressWidth - IndexWidth - 2;

    logic [Lines-1:0]    valid_q;
    logic [TagWidth-1:0] tag_q  [Lines];
    logic [IDWidth-1:0]  data_q [Lines];

    logic [IndexWidth-1:0] rd_idx;
    logic [IndexWidth-1:0] wr_idx;
    logic [TagWidth-1:0]   rd_tag;
    logic [TagWidth-1:0]   wr_tag;
    logic                  unused_addr_bits;

    assign rd_idx           = rd_addr_i[IndexWidth+1:2];
    assign wr_idx           = wr_addr_i[IndexWidth+1:2];
    assign rd_tag           = rd_addr_i[AddressWidth-1:IndexWidth+2];
    assign wr_tag           = wr_addr_i[AddressWidth-1:IndexWidth+2];
    assign unused_addr_bits = ^{rd_addr_i[1:0], wr_addr_i[1:0]};

    // Only the valid bits need clearing; stale tag/data behind a cleared bit are harmless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data_i;
        end
    end

    assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data_o = data_q[rd_idx];

endmodule

// File: rtl/instfetch.sv
// Fetch unit: walks the PC through the icache, fills misses from memory and
// pushes one {inst, pc} per cycle to the instruction queue.
module instfetch
    import instfetch_pkg::*;
#(
    parameter int unsigned             ICacheLines      = ICacheLinesDefault,
    parameter int unsigned             ICacheIndexWidth = 4,
    parameter logic [AddressWidth-1:0] ResetPC          = '0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    instqueue_if_rdy_in,
    output logic                    if_instqueue_en_out,
    output logic [IDWidth-1:0]      if_instqueue_inst_out,
    output logic [AddressWidth-1:0] if_instqueue_pc_out,
    output logic                    if_mc_en_out,
    output logic [AddressWidth-1:0] if_mc_addr_out,
    input  logic                    mc_if_rdy_in,
    input  logic [IDWidth-1:0]      mc_if_data_in,
    input  logic                    rob_if_rst_in,
    input  logic [AddressWidth-1:0] rob_if_pc_in
);

    if_state_e               state_q;
    logic [AddressWidth-1:0] pc_q;
    logic [AddressWidth-1:0] mc_addr_q;
    logic [AddressWidth-1:0] iq_pc_q;
    logic [IDWidth-1:0]      iq_inst_q;
    logic                    iq_en_q;
    logic                    mc_en_q;

    logic               hit;
    logic [IDWidth-1:0] hit_data;
    logic               fill_en;
    logic               unused_rob_pc_bits;

    // A fill landing in the same cycle as a redirect is still correct for its address.
    assign fill_en            = rdy_in && (state_q == StWait) && mc_if_rdy_in;
    assign unused_rob_pc_bits = ^rob_if_pc_in[1:0];

    instfetch_icache #(
        .Lines      (ICacheLines),
        .IndexWidth (ICacheIndexWidth)
    ) u_icache (
        .clk_i     (clk_in),
        .rst_ni    (rst_in),
        .rd_addr_i (pc_q),
        .rd_hit_o  (hit),
        .rd_data_o (hit_data),
        .wr_en_i   (fill_en),
        .wr_addr_i (mc_addr_q),
        .wr_data_i (mc_if_data_in)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= StLookup;
            pc_q      <= ResetPC;
            mc_addr_q <= '0;
            mc_en_q   <= 1'b0;
            iq_en_q   <= 1'b0;
            iq_inst_q <= '0;
            iq_pc_q   <= '0;
        end else if (rdy_in) begin
            iq_en_q <= 1'b0;
            if (rob_if_rst_in) begin
                pc_q    <= {rob_if_pc_in[AddressWidth-1:2], 2'b00};
                state_q <= StLookup;
                mc_en_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StLookup: begin
                        if (hit) begin
                            if (instqueue_if_rdy_in) begin
                                iq_en_q   <= 1'b1;
                                iq_inst_q <= hit_data;
                                iq_pc_q   <= pc_q;
                                pc_q      <= pc_q + AddressWidth'(4);
                            end
                        end else begin
                            mc_en_q   <= 1'b1;
                            mc_addr_q <= pc_q;
                            state_q   <= StWait;
                        end
                    end
                    StWait: begin
                        if (mc_if_rdy_in) begin
                            mc_en_q <= 1'b0;
                            state_q <= StLookup;
                        end
                    end
                endcase
            end
        end
    end

    assign if_instqueue_en_out   = iq_en_q;
    assign if_instqueue_inst_out = iq_inst_q;
    assign if_instqueue_pc_out   = iq_pc_q;
    assign if_mc_en_out          = mc_en_q;
    assign if_mc_addr_out        = mc_addr_q;

endmodule

// File: tb/tb_instfetch.sv
// Bench for instfetch: memory-controller model, push scoreboard and directed/random scenarios.
`timescale 1ns/1ps
module tb_instfetch;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, instqueue_if_rdy_in, mc_if_rdy_in, rob_if_rst_in;
    logic [31:0] mc_if_data_in, rob_if_pc_in;
    logic        if_instqueue_en_out, if_mc_en_out;
    logic [31:0] if_instqueue_inst_out, if_instqueue_pc_out, if_mc_addr_out;

    int tests = 0, fails = 0, cyc = 0, pushes = 0, last_strobe = -100;
    int stall_pct = 0, lat = 3, cur_lat = 3, cnt = 0;
    bit lat_rand = 1'b0, mem_const = 1'b1, prev_en = 1'b0;
    logic [31:0] exp_pc = 32'h0, req_addr = 32'h0;

    always #5 clk = ~clk;

    instfetch #(
        .ICacheLines      (16),
        .ICacheIndexWidth (4),
        .ResetPC          (32'h0)
    ) dut (
        .clk_in                (clk),
        .rst_in                (rst_in),
        .rdy_in                (rdy_in),
        .instqueue_if_rdy_in   (instqueue_if_rdy_in),
        .if_instqueue_en_out   (if_instqueue_en_out),
        .if_instqueue_inst_out (if_instqueue_inst_out),
        .if_instqueue_pc_out   (if_instqueue_pc_out),
        .if_mc_en_out          (if_mc_en_out),
        .if_mc_addr_out        (if_mc_addr_out),
        .mc_if_rdy_in          (mc_if_rdy_in),
        .mc_if_data_in         (mc_if_data_in),
        .rob_if_rst_in         (rob_if_rst_in),
        .rob_if_pc_in          (rob_if_pc_in)
    );

    // Memory image: either the constant nop or a per-address scrambled word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_const) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Negedge: memory controller and global stall; +3: push scoreboard on the coming edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_in) begin
            cnt = 0; mc_if_rdy_in = 1'b0; rdy_in = 1'b1; prev_en = 1'b0;
        end else begin
            mc_if_rdy_in = 1'b0;
            rdy_in = ($urandom_range(99) >= stall_pct);
            if (if_mc_en_out) begin
                if (!prev_en) begin
                    tests++;
                    if (if_mc_addr_out !== exp_pc) begin
                        fails++;
                        $display("FAIL sb_req_addr got=%h want=%h", if_mc_addr_out, exp_pc);
                    end
                    req_addr = if_mc_addr_out;
                    cnt = 0;
                    cur_lat = lat_rand ? int'($urandom_range(1, 4)) : lat;
                end
                if (rdy_in) begin
                    cnt++;
                    if (cnt == cur_lat) begin
                        mc_if_rdy_in  = 1'b1;
                        mc_if_data_in = mem_word(req_addr);
                        last_strobe   = cyc;
                    end
                end
            end
            prev_en = if_mc_en_out;
        end
        #3;
        if (rst_in && rdy_in) begin
            if (if_instqueue_en_out && !rob_if_rst_in) begin
                tests++;
                pushes++;
                if (if_instqueue_pc_out !== exp_pc || if_instqueue_inst_out !== mem_word(exp_pc)) begin
                    fails++;
                    $display("FAIL sb_push got=pc %h inst %h want=pc %h inst %h",
                             if_instqueue_pc_out, if_instqueue_inst_out, exp_pc, mem_word(exp_pc));
                end
                exp_pc = if_instqueue_pc_out + 32'd4;
            end
            if (rob_if_rst_in) exp_pc = {rob_if_pc_in[31:2], 2'b00};
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Called at negedge+2; holds the redirect over exactly one accepted edge.
    task automatic pulse_redirect(input logic [31:0] target);
        int guard = 0;
        rob_if_pc_in  = target;
        rob_if_rst_in = 1'b1;
        while (!rdy_in && guard < 100) begin tick(); guard++; end
        tick();
        rob_if_rst_in = 1'b0;
    endtask

    task automatic wait_push(input logic [31:0] pc, input string name);
        int i = 0;
        while (!(if_instqueue_en_out === 1'b1 && if_instqueue_pc_out === pc) && i < 200) begin
            tick(); i++;
        end
        if (i >= 200) begin
            tests++; fails++;
            $display("FAIL %s_timeout got=no push want=push of pc %h", name, pc);
        end
    endtask

    task automatic wait_req(input string name);
        int i = 0;
        while (if_mc_en_out !== 1'b1 && i < 200) begin tick(); i++; end
        if (i >= 200) begin
            tests++; fails++;
            $display("FAIL %s_timeout got=no request want=if_mc_en_out high", name);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        #1 rst_in = 1'b0;
        #1;
        tests += 5;
        if (if_instqueue_en_out !== 1'b0) begin fails++; $display("FAIL rst_en got=%b want=0", if_instqueue_en_out); end
        if (if_instqueue_inst_out !== 32'h0) begin fails++; $display("FAIL rst_inst got=%h want=0", if_instqueue_inst_out); end
        if (if_instqueue_pc_out !== 32'h0) begin fails++; $display("FAIL rst_pc got=%h want=0", if_instqueue_pc_out); end
        if (if_mc_en_out !== 1'b0) begin fails++; $display("FAIL rst_mc_en got=%b want=0", if_mc_en_out); end
        if (if_mc_addr_out !== 32'h0) begin fails++; $display("FAIL rst_mc_addr got=%h want=0", if_mc_addr_out); end
    endtask

    task automatic test_cold_start();
        int i = 0;
        mem_const = 1'b1; lat = 3; instqueue_if_rdy_in = 1'b1;
        tick();
        rst_in = 1'b1;
        tick();
        tests++;
        if (if_mc_en_out !== 1'b1 || if_mc_addr_out !== 32'h0) begin
            fails++; $display("FAIL cold_req got=en %b addr %h want=en 1 addr 0", if_mc_en_out, if_mc_addr_out);
        end
        while (if_instqueue_en_out !== 1'b1 && i < 50) begin tick(); i++; end
        tests++;
        if (if_instqueue_pc_out !== 32'h0 || if_instqueue_inst_out !== 32'h13 || cyc - last_strobe != 2) begin
            fails++;
            $display("FAIL cold_push got=pc %h inst %h lag %0d want=pc 0 inst 13 lag 2",
                     if_instqueue_pc_out, if_instqueue_inst_out, cyc - last_strobe);
        end
        tick();
        tests++;
        if (if_mc_en_out !== 1'b1 || if_mc_addr_out !== 32'h4) begin
            fails++; $display("FAIL cold_next_req got=en %b addr %h want=en 1 addr 4", if_mc_en_out, if_mc_addr_out);
        end
    endtask

    task automatic test_warm_loop();
        wait_push(32'hC, "warm_fill");
        pulse_redirect(32'h0);
        tests++;
        if (if_instqueue_en_out !== 1'b0) begin fails++; $display("FAIL warm_flush got=en %b want=0", if_instqueue_en_out); end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (if_instqueue_en_out !== 1'b1 || if_instqueue_pc_out !== 32'(4 * k) || if_mc_en_out !== 1'b0) begin
                fails++;
                $display("FAIL warm_push%0d got=en %b pc %h mc_en %b want=en 1 pc %h mc_en 0",
                         k, if_instqueue_en_out, if_instqueue_pc_out, if_mc_en_out, 32'(4 * k));
            end
        end
    endtask

    task automatic test_back_pressure();
        pulse_redirect(32'h0);
        tick();
        tick();
        tests++;
        if (if_instqueue_en_out !== 1'b1 || if_instqueue_pc_out !== 32'h4) begin
            fails++; $display("FAIL bp_pre got=en %b pc %h want=en 1 pc 4", if_instqueue_en_out, if_instqueue_pc_out);
        end
        instqueue_if_rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (if_instqueue_en_out !== 1'b0 || if_mc_en_out !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d got=en %b mc_en %b want=0 0", i, if_instqueue_en_out, if_mc_en_out);
            end
        end
        instqueue_if_rdy_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (if_instqueue_en_out !== 1'b1 || if_instqueue_pc_out !== 32'(8 + 4 * k)) begin
                fails++;
                $display("FAIL bp_resume%0d got=en %b pc %h want=en 1 pc %h",
                         k, if_instqueue_en_out, if_instqueue_pc_out, 32'(8 + 4 * k));
            end
        end
    endtask

    task automatic test_redirect_mid_miss();
        lat = 12;
        pulse_redirect(32'h40);
        wait_req("mid_miss_req");
        tests++;
        if (if_mc_addr_out !== 32'h40) begin fails++; $display("FAIL mid_miss_addr got=%h want=40", if_mc_addr_out); end
        tick();
        pulse_redirect(32'h103);
        lat = 3;
        tests++;
        if (if_mc_en_out !== 1'b0) begin fails++; $display("FAIL mid_miss_abort got=%b want=0", if_mc_en_out); end
        tick();
        tests++;
        if (if_mc_en_out !== 1'b1 || if_mc_addr_out !== 32'h100) begin
            fails++; $display("FAIL mid_miss_new_req got=en %b addr %h want=en 1 addr 100", if_mc_en_out, if_mc_addr_out);
        end
        while (if_instqueue_en_out !== 1'b1 && cnt < 50) tick();
        tests++;
        if (if_instqueue_pc_out !== 32'h100) begin fails++; $display("FAIL mid_miss_first_push got=%h want=100", if_instqueue_pc_out); end
    endtask

    task automatic test_conflict_evict();
        pulse_redirect(32'h0);
        wait_push(32'h0, "evict_fill0");
        pulse_redirect(32'h40);
        wait_push(32'h40, "evict_fill40");
        pulse_redirect(32'h0);
        tick();
        tests++;
        if (if_mc_en_out !== 1'b1 || if_mc_addr_out !== 32'h0 || if_instqueue_en_out !== 1'b0) begin
            fails++;
            $display("FAIL evict_refetch got=mc_en %b addr %h en %b want=mc_en 1 addr 0 en 0",
                     if_mc_en_out, if_mc_addr_out, if_instqueue_en_out);
        end
        wait_push(32'h0, "evict_refill0");
    endtask

    task automatic test_async_reset();
        lat = 20;
        pulse_redirect(32'h200);
        wait_req("areset_req");
        rst_in = 1'b0;
        #1;
        tests += 3;
        if (if_mc_en_out !== 1'b0) begin fails++; $display("FAIL areset_mc_en got=%b want=0", if_mc_en_out); end
        if (if_mc_addr_out !== 32'h0) begin fails++; $display("FAIL areset_mc_addr got=%h want=0", if_mc_addr_out); end
        if (if_instqueue_pc_out !== 32'h0) begin fails++; $display("FAIL areset_pc got=%h want=0", if_instqueue_pc_out); end
        exp_pc = 32'h0;
        mem_const = 1'b0;
        lat = 3;
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        tests++;
        if (if_mc_en_out !== 1'b1 || if_mc_addr_out !== 32'h0) begin
            fails++; $display("FAIL areset_cold_miss got=en %b addr %h want=en 1 addr 0", if_mc_en_out, if_mc_addr_out);
        end
        wait_push(32'h0, "areset_push");
        tests++;
        if (if_instqueue_inst_out !== mem_word(32'h0)) begin
            fails++; $display("FAIL areset_inst got=%h want=%h", if_instqueue_inst_out, mem_word(32'h0));
        end
    endtask

    task automatic test_random();
        int start = pushes;
        lat_rand = 1'b1; stall_pct = 20; mem_const = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            instqueue_if_rdy_in = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 4) pulse_redirect($urandom_range(0, 32'h3FF));
        end
        stall_pct = 0; lat_rand = 1'b0; instqueue_if_rdy_in = 1'b1;
        tick();
        tests++;
        if (pushes - start < 100) begin fails++; $display("FAIL rand_progress got=%0d pushes want>=100", pushes - start); end
    endtask

    initial begin
        rdy_in = 1'b1; instqueue_if_rdy_in = 1'b1; mc_if_rdy_in = 1'b0; mc_if_data_in = 32'h0;
        rob_if_rst_in = 1'b0; rob_if_pc_in = 32'h0;
        test_reset();
        test_cold_start();
        test_warm_loop();
        test_back_pressure();
        test_redirect_mid_miss();
        test_conflict_evict();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=still running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
